// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath: decoded
// instruction fields, ALU flags and memory handshake in, strobes and selects out.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       signedLess;
    logic       unsignedLess;
    logic       mem_ready;

    logic       PCWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       MemRead;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic       fault;
    logic [3:0] state;

    modport master (
        input  op, funct3, funct7b5, Zero, signedLess, unsignedLess, mem_ready,
        output PCWrite, IRWrite, RegWrite, MemWrite, MemRead, AdrSrc,
        output ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, fault, state
    );

    modport slave (
        output op, funct3, funct7b5, Zero, signedLess, unsignedLess, mem_ready,
        input  PCWrite, IRWrite, RegWrite, MemWrite, MemRead, AdrSrc,
        input  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, fault, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I-style control FSM with a memory-wait watchdog that parks the
// controller in a sticky FAULT state until reset.
module multicycle_controller #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_controller_if.master bus
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR_ADR = 4'd11;
    localparam logic [3:0] S_UPPER    = 4'd12;
    localparam logic [3:0] S_FAULT    = 4'd13;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_LUI = 4'b0111;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT - 1);

    logic [3:0] cur, nxt;
    logic [7:0] cnt;
    logic       waiting, timeout;
    logic       pcw, irw, rw, mw, mrd;

    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7,
                                              input logic allow_sub);
        case (f3)
            3'b000:  alu_decode = (allow_sub && f7) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_decode = 4'b1000;
            3'b010:  alu_decode = 4'b0110;
            3'b011:  alu_decode = 4'b0101;
            3'b100:  alu_decode = 4'b0100;
            3'b101:  alu_decode = f7 ? 4'b1010 : 4'b1001;
            3'b110:  alu_decode = 4'b0011;
            default: alu_decode = 4'b0010;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                          input logic sl, input logic ul);
        case (f3)
            3'b000:  branch_taken = z;
            3'b001:  branch_taken = !z;
            3'b100:  branch_taken = sl;
            3'b101:  branch_taken = !sl;
            3'b110:  branch_taken = ul;
            3'b111:  branch_taken = !ul;
            default: branch_taken = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] imm_select(input logic [6:0] opc, input logic [2:0] f3);
        case (opc)
            OP_STORE:         imm_select = 3'b001;
            OP_B:             imm_select = 3'b010;
            OP_JAL:           imm_select = 3'b011;
            OP_LUI, OP_AUIPC: imm_select = 3'b100;
            OP_I:             imm_select = (f3 == 3'b001 || f3 == 3'b101) ? 3'b101 : 3'b000;
            default:          imm_select = 3'b000;
        endcase
    endfunction

    // Watchdog trips on the MAX_WAIT-th consecutive cycle without mem_ready.
    assign waiting = (cur == S_FETCH) || (cur == S_MEMREAD) || (cur == S_MEMWRITE);
    assign timeout = waiting && !bus.mem_ready && (cnt == WAIT_LIMIT);

    always_comb begin
        pcw            = 1'b0;
        irw            = 1'b0;
        rw             = 1'b0;
        mw             = 1'b0;
        mrd            = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.ResultSrc  = 2'b00;
        bus.ImmSrc     = 3'b000;
        bus.ALUControl = ALU_ADD;
        nxt            = cur;
        case (cur)
            S_FETCH: begin
                mrd = 1'b1;
                if (bus.mem_ready) begin
                    irw           = 1'b1;
                    pcw           = 1'b1;
                    bus.ALUSrcB   = 2'b10;
                    bus.ResultSrc = 2'b10;
                    nxt           = S_DECODE;
                end
            end
            S_DECODE: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
                bus.ImmSrc  = imm_select(bus.op, bus.funct3);
                case (bus.op)
                    OP_LOAD, OP_STORE: nxt = S_MEMADR;
                    OP_R:              nxt = S_EXECR;
                    OP_I:              nxt = S_EXECI;
                    OP_B:              nxt = S_BRANCH;
                    OP_JAL:            nxt = S_JAL;
                    OP_JALR:           nxt = S_JALR_ADR;
                    OP_LUI, OP_AUIPC:  nxt = S_UPPER;
                    default:           nxt = S_FAULT;
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                nxt         = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                bus.AdrSrc = 1'b1;
                mrd        = 1'b1;
                if (bus.mem_ready) nxt = S_MEMWB;
            end
            S_MEMWB: begin
                bus.ResultSrc = 2'b01;
                rw            = 1'b1;
                nxt           = S_FETCH;
            end
            S_MEMWRITE: begin
                bus.AdrSrc = 1'b1;
                mw         = 1'b1;
                if (bus.mem_ready) nxt = S_FETCH;
            end
            S_EXECR: begin
                bus.ALUSrcA    = 2'b10;
                bus.ALUControl = alu_decode(bus.funct3, bus.funct7b5, 1'b1);
                nxt            = S_ALUWB;
            end
            S_EXECI: begin
                bus.ALUSrcA    = 2'b10;
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = alu_decode(bus.funct3, bus.funct7b5, 1'b0);
                nxt            = S_ALUWB;
            end
            S_ALUWB: begin
                rw  = 1'b1;
                nxt = S_FETCH;
            end
            S_BRANCH: begin
                bus.ALUSrcA    = 2'b10;
                bus.ALUControl = ALU_SUB;
                pcw            = branch_taken(bus.funct3, bus.Zero, bus.signedLess,
                                              bus.unsignedLess);
                nxt            = S_FETCH;
            end
            S_JALR_ADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                nxt         = S_JAL;
            end
            S_JAL: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                pcw         = 1'b1;
                nxt         = S_ALUWB;
            end
            S_UPPER: begin
                bus.ALUSrcB = 2'b01;
                if (bus.op == OP_LUI) begin
                    bus.ALUControl = ALU_LUI;
                end else begin
                    bus.ALUSrcA = 2'b01;
                end
                nxt = S_ALUWB;
            end
            S_FAULT: nxt = S_FAULT;
            default: nxt = S_FAULT;
        endcase
        if (timeout) nxt = S_FAULT;
    end

    // Strobes are gated by reset so an in-flight access is abandoned immediately.
    assign bus.PCWrite  = pcw && !rst;
    assign bus.IRWrite  = irw && !rst;
    assign bus.RegWrite = rw  && !rst;
    assign bus.MemWrite = mw  && !rst;
    assign bus.MemRead  = mrd && !rst;
    assign bus.fault    = (cur == S_FAULT);
    assign bus.state    = cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= S_FETCH;
            cnt <= 8'd0;
        end else begin
            cur <= nxt;
            if (nxt != cur) begin
                cnt <= 8'd0;
            end else if (waiting && !bus.mem_ready) begin
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule
